// File: rtl/mac_accumulator.sv
// Streaming unsigned multiply-accumulate stage.
// Operand pairs arrive over a valid/ready handshake and are multiplied by an
// 8x8 unsigned multiplier. The products are summed into a wide accumulator.
// When the beat marked last has been summed, the dot product, the beat count
// and a sticky overflow flag are held on a valid/ready output port until the
// consumer takes them.

module unsigned_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);
    // Purely combinational 8x8 product; the consumer registers it.
    assign product = a * b;
endmodule

module mac_accumulator #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic [15:0]      count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     product;
    logic [15:0]     prod_r;
    logic            last_r;
    logic            p_valid;
    logic            last_pend;
    logic            accept;
    logic [ACC_W:0]  sum;

    unsigned_multiplier u_mult (
        .a       (a),
        .b       (b),
        .product (product)
    );

    // Once a last beat is in the pipe, no further beats are taken until the
    // result has been handed off, so vectors can never interleave.
    assign in_ready  = rst_n && (state != DONE) && !last_pend;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // One extra bit on the adder exposes the carry out of the accumulator.
    assign sum = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, prod_r};

    // Stage 1: capture the product of each accepted beat along with its last marker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_r  <= '0;
            last_r  <= 1'b0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                prod_r <= product;
                last_r <= in_last;
            end
        end
    end

    // Track that the final beat of the current vector has already been accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pend <= 1'b0;
        end else if (accept && in_last) begin
            last_pend <= 1'b1;
        end else if (state == DONE && out_ready) begin
            last_pend <= 1'b0;
        end
    end

    // Stage 2 and control: accumulate products, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (p_valid) begin
                        acc      <= sum[ACC_W-1:0];
                        count    <= (count == 16'hFFFF) ? count : count + 16'd1;
                        overflow <= overflow | sum[ACC_W];
                        state    <= last_r ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator.
// Two instances (24-bit and 16-bit accumulators) see identical stimulus.
// The driver pushes expected vector results into a scoreboard; a monitor on the
// falling edge compares every presented result against it.

module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [23:0] acc;
    logic [15:0] count;
    logic        overflow;

    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] acc16;
    logic [15:0] count16;
    logic        overflow16;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint sum;
        int     beats;
    } exp_t;

    exp_t   sb[$];
    longint model_sum = 0;
    int     model_beats = 0;
    int     cycle = 0;
    int     last_edge = 0;
    bit     prev_valid = 0;
    bit     hs_prev = 0;
    bit     reset_prev = 0;

    mac_accumulator #(.ACC_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .count     (count),
        .overflow  (overflow)
    );

    mac_accumulator #(.ACC_W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .acc       (acc16),
        .count     (count16),
        .overflow  (overflow16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Watchdog so the run always ends even if the handshake locks up.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Expected result fields derived from plain arithmetic on the vector sum.
    function automatic longint expAcc(input longint s, input int w);
        return s % (longint'(1) << w);
    endfunction

    function automatic longint expOvf(input longint s, input int w);
        return (s >= (longint'(1) << w)) ? 1 : 0;
    endfunction

    function automatic longint expCount(input int n);
        return (n > 65535) ? 65535 : n;
    endfunction

    // Monitor: models accepts, checks presented results, reset and handshake timing.
    always @(negedge clk) begin
        if (reset_prev) begin
            checkOutput("reset_acc", acc, 0);
            checkOutput("reset_count", count, 0);
            checkOutput("reset_overflow", overflow, 0);
            checkOutput("reset_out_valid", out_valid, 0);
            checkOutput("reset_in_ready", in_ready, rst_n);
            checkOutput("reset_acc16", acc16, 0);
            reset_prev = 0;
        end
        if (hs_prev) begin
            checkOutput("valid_drop_after_hs", out_valid, 0);
            if (rst_n) checkOutput("in_ready_after_hs", in_ready, 1);
            hs_prev = 0;
        end
        if (!rst_n) begin
            checkOutput("in_ready_in_reset", in_ready, 0);
            sb.delete();
            model_sum   = 0;
            model_beats = 0;
            prev_valid  = 0;
            reset_prev  = 1;
        end else begin
            if (out_valid) begin
                if (!prev_valid) checkOutput("result_latency", cycle, last_edge + 1);
                checkOutput("in_ready_low_in_done", in_ready, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: actual=acc %0d required=no result", acc);
                end else begin
                    checkOutput("acc24", acc, expAcc(sb[0].sum, 24));
                    checkOutput("count24", count, expCount(sb[0].beats));
                    checkOutput("overflow24", overflow, expOvf(sb[0].sum, 24));
                    checkOutput("out_valid16", out_valid16, 1);
                    checkOutput("acc16", acc16, expAcc(sb[0].sum, 16));
                    checkOutput("count16", count16, expCount(sb[0].beats));
                    checkOutput("overflow16", overflow16, expOvf(sb[0].sum, 16));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        hs_prev = 1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                model_sum   += longint'(a) * longint'(b);
                model_beats += 1;
                last_edge    = cycle + 1;
                if (in_last) begin
                    sb.push_back('{sum: model_sum, beats: model_beats});
                    model_sum   = 0;
                    model_beats = 0;
                end
            end
        end
        prev_valid = out_valid && !out_ready && rst_n;
    end

    // Present one beat after an optional idle gap and hold it until accepted.
    task automatic applyStimulus(input logic [7:0] a_i, input logic [7:0] b_i,
                                 input logic last_i, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        a        = a_i;
        b        = b_i;
        in_last  = last_i;
        in_valid = 1'b1;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: actual=in_ready 0 required=beat accepted");
        in_valid = 1'b0;
    endtask

    // Wait until every expected result has been taken and the output is idle.
    task automatic waitDrain();
        for (int w = 0; w < 300; w++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL drain_timeout: actual=%0d pending required=0 pending", sb.size());
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three-beat vector: 12 + 200 + 65025.
        applyStimulus(8'd3, 8'd4, 1'b0, 0);
        applyStimulus(8'd10, 8'd20, 1'b0, 0);
        applyStimulus(8'd255, 8'd255, 1'b1, 0);
        waitDrain();

        // Single-beat vectors with zero operand, then state cleared between vectors.
        applyStimulus(8'd0, 8'd200, 1'b1, 0);
        applyStimulus(8'd7, 8'd9, 1'b1, 0);
        waitDrain();

        // Back-pressure on the result while a new beat waits upstream.
        out_ready = 1'b0;
        applyStimulus(8'd5, 8'd6, 1'b1, 0);
        a        = 8'd1;
        b        = 8'd1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(8'd1, 8'd1, 1'b1, 0);
        waitDrain();

        // Wraps the 16-bit accumulator, then a clean vector clears the flag.
        applyStimulus(8'd255, 8'd255, 1'b0, 0);
        applyStimulus(8'd255, 8'd255, 1'b1, 0);
        applyStimulus(8'd1, 8'd1, 1'b1, 0);
        waitDrain();

        // Fifteen random beats with random idle gaps.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          (i == 14), $urandom_range(0, 2));
        end
        waitDrain();

        // Reset in the middle of a four-beat vector aborts it.
        applyStimulus(8'd9, 8'd9, 1'b0, 0);
        applyStimulus(8'd8, 8'd8, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'd2, 8'd3, 1'b1, 0);
        waitDrain();

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
